// File: rtl/uart_rx_byte_if.sv
// Receive-side bus from uart_rx_byte: the framed byte, its qualifiers and the busy flag.
// The receiver drives the master modport; the downstream consumer listens on slave.
interface uart_rx_byte_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       busy;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_frame_err,
    output busy
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input rx_frame_err,
    input busy
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: two-flop synchroniser on rx_i, mid-bit sampling FSM, one-cycle
// byte-ready / frame-error strobes and a held last-good byte for the downstream bus.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line idle, waiting for rx_s low (start edge)
// S_START | half-bit wait, re-check start bit to reject glitches
// S_DATA  | sample 8 data bits LSB first, one per bit period
// S_STOP  | sample stop bit; high = good byte, low = framing error
// S_BREAK | line held low after a framing error; wait for it to go high
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx_i,
  uart_rx_byte_if.master rx_bus
);

  if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_param
    $error("uart_rx_byte: CLKS_PER_BIT must be even and >= 4");
  end

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] C_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] C_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] C_ONE  = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic          w_rx_s;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_frame_err;
  logic          r_busy;

  // Flops reset high so a reset never looks like a start edge by itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state <= S_START;
            r_timer <= '0;
            r_busy  <= 1'b1;
          end
        end

        S_START: begin
          if (r_timer == C_HALF) begin
            r_timer <= '0;
            if (w_rx_s) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= S_DATA;
              r_bit_idx <= '0;
            end
          end else begin
            r_timer <= r_timer + C_ONE;
          end
        end

        S_DATA: begin
          if (r_timer == C_FULL) begin
            r_timer   <= '0;
            r_shift   <= {w_rx_s, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_timer <= r_timer + C_ONE;
          end
        end

        S_STOP: begin
          if (r_timer == C_FULL) begin
            r_timer <= '0;
            if (w_rx_s) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end
          end else begin
            r_timer <= r_timer + C_ONE;
          end
        end

        S_BREAK: begin
          if (w_rx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_bus.rx_data      = r_data;
  assign rx_bus.rx_valid     = r_valid;
  assign rx_bus.rx_frame_err = r_frame_err;
  assign rx_bus.busy         = r_busy;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clk/bit: reset, single byte, back-to-back,
// glitch rejection, framing error with break, and reset in the middle of a frame.
module tb_uart_rx_byte;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_i = 1'b0;

  uart_rx_byte_if bus ();

  uart_rx_byte #(.CLKS_PER_BIT(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .rx_i   (rx_i),
    .rx_bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         q_v_cyc[$];
  logic [7:0] q_v_data[$];
  int         n_ferr = 0;
  int         last_ferr_cyc = -1;
  int         n_both = 0;
  logic       prev_valid = 1'b0;
  logic       busy_after_valid = 1'bx;

  // Pulse recorder, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      q_v_cyc.push_back(cyc);
      q_v_data.push_back(bus.rx_data);
    end
    if (bus.rx_frame_err === 1'b1) begin
      n_ferr++;
      last_ferr_cyc = cyc;
    end
    if (bus.rx_valid === 1'b1 && bus.rx_frame_err === 1'b1) n_both++;
    if (prev_valid) busy_after_valid = bus.busy;
    prev_valid = bus.rx_valid;
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one full frame; c is the cycle in which the start bit was put on rx_i.
  task automatic send_byte(input logic [7:0] b, input logic stop_lvl, output int c);
    c = cyc;
    rx_i = 1'b0;
    tick(N);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      tick(N);
    end
    rx_i = stop_lvl;
    tick(N);
  endtask

  int c1, c2, c3, cg, h, v0, f0;
  logic [7:0] mid_byte;

  initial begin
    // Reset held with the line low: all outputs stay at reset values.
    rst  = 1'b1;
    rx_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_data",  {24'd0, bus.rx_data}, 32'h00);
      check("rst_valid", {31'd0, bus.rx_valid}, 32'd0);
      check("rst_ferr",  {31'd0, bus.rx_frame_err}, 32'd0);
      check("rst_busy",  {31'd0, bus.busy}, 32'd0);
    end
    rst = 1'b0;
    tick(2);
    check("rel_busy_+2", {31'd0, bus.busy}, 32'd0);
    tick(1);
    check("rel_busy_+3", {31'd0, bus.busy}, 32'd1);
    rx_i = 1'b1;
    tick(30);
    check("rel_no_valid", q_v_cyc.size(), 0);
    check("rel_no_ferr",  n_ferr, 0);
    check("rel_idle",     {31'd0, bus.busy}, 32'd0);

    // Single byte 0xA5
    v0 = q_v_cyc.size();
    f0 = n_ferr;
    send_byte(8'hA5, 1'b1, c1);
    tick(4);
    check("a5_count", q_v_cyc.size() - v0, 1);
    if (q_v_cyc.size() > v0) begin
      check("a5_cycle", q_v_cyc[v0], c1 + 2 + 152 + 1);
      check("a5_data",  {24'd0, q_v_data[v0]}, 32'hA5);
    end
    check("a5_no_ferr",    n_ferr - f0, 0);
    check("a5_busy_after", {31'd0, busy_after_valid}, 32'd0);
    check("a5_hold",       {24'd0, bus.rx_data}, 32'hA5);

    // Back-to-back 0x00, 0xFF, 0x3C with no idle gap
    v0 = q_v_cyc.size();
    send_byte(8'h00, 1'b1, c1);
    send_byte(8'hFF, 1'b1, c2);
    send_byte(8'h3C, 1'b1, c3);
    tick(10);
    check("b2b_count", q_v_cyc.size() - v0, 3);
    if (q_v_cyc.size() >= v0 + 3) begin
      check("b2b_d0", {24'd0, q_v_data[v0]},     32'h00);
      check("b2b_d1", {24'd0, q_v_data[v0 + 1]}, 32'hFF);
      check("b2b_d2", {24'd0, q_v_data[v0 + 2]}, 32'h3C);
      check("b2b_t0", q_v_cyc[v0],     c1 + 155);
      check("b2b_t1", q_v_cyc[v0 + 1], c1 + 155 + 160);
      check("b2b_t2", q_v_cyc[v0 + 2], c1 + 155 + 320);
    end
    check("b2b_no_ferr", n_ferr - f0, 0);

    // Glitch: 4 low cycles, then high
    v0 = q_v_cyc.size();
    rx_i = 1'b0;
    tick(4);
    rx_i = 1'b1;
    cg = cyc;
    tick(10);
    check("glitch_busy", {31'd0, bus.busy}, 32'd0);
    tick(10);
    check("glitch_no_valid", q_v_cyc.size() - v0, 0);
    check("glitch_no_ferr",  n_ferr - f0, 0);
    send_byte(8'h81, 1'b1, c1);
    tick(4);
    check("g81_count", q_v_cyc.size() - v0, 1);
    if (q_v_cyc.size() > v0) begin
      check("g81_data",  {24'd0, q_v_data[v0]}, 32'h81);
      check("g81_cycle", q_v_cyc[v0], c1 + 155);
    end

    // Framing error followed by a 400-cycle break
    v0 = q_v_cyc.size();
    send_byte(8'h55, 1'b0, c1);
    tick(400);
    check("fe_count",  n_ferr - f0, 1);
    check("fe_cycle",  last_ferr_cyc, c1 + 155);
    check("fe_no_valid", q_v_cyc.size() - v0, 0);
    check("fe_data_kept", {24'd0, bus.rx_data}, 32'h81);
    check("fe_busy_break", {31'd0, bus.busy}, 32'd1);
    rx_i = 1'b1;
    h = cyc;
    tick(1);
    check("brk_busy_+1", {31'd0, bus.busy}, 32'd1);
    tick(2);
    check("brk_busy_+3", {31'd0, bus.busy}, 32'd0);
    tick(30);
    check("brk_one_ferr", n_ferr - f0, 1);
    check("brk_no_start", q_v_cyc.size() - v0, 0);

    // Reset in the middle of bit 4 of 0xC3, then receive 0x12
    v0 = q_v_cyc.size();
    f0 = n_ferr;
    mid_byte = 8'hC3;
    rx_i = 1'b0;
    tick(N);
    for (int i = 0; i < 4; i++) begin
      rx_i = mid_byte[i];
      tick(N);
    end
    rx_i = mid_byte[4];
    tick(N / 2);
    check("mid_busy_pre", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_data", {24'd0, bus.rx_data}, 32'h00);
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    tick(2);
    rx_i = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(20);
    check("mid_no_valid", q_v_cyc.size() - v0, 0);
    send_byte(8'h12, 1'b1, c1);
    tick(4);
    check("m12_count", q_v_cyc.size() - v0, 1);
    if (q_v_cyc.size() > v0) begin
      check("m12_data", {24'd0, q_v_data[v0]}, 32'h12);
    end
    check("m12_no_ferr", n_ferr - f0, 0);

    check("never_both", n_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
